bcd_addsub_seq: RTL and testbench
=================================

# bcd_addsub_seq

Digit-serial, parametrised BCD add/subtract engine with a start/done handshake. It processes one decimal digit per clock, least-significant digit first. Subtraction returns a signed-magnitude result (magnitude plus negative flag), not a raw ten's-complement word. It sits between the pushbutton/UART operand capture logic and the seven-segment display path in `top`, and replaces the combinational BCD adder chain for wide operands.

## Interface
- DIGITS, 4: number of BCD digits per operand and result; legal range 1–8.
- hz100  in  1: system clock; all state changes on its rising edge.
- reset  in  1: synchronous, active-high reset.
- start  in  1: request an operation; sampled only in IDLE.
- op  in  1: 0 = a + b, 1 = a − b; sampled with start.
- a  in  4*DIGITS: BCD operand A, digit i at [4i+3:4i]; sampled with start.
- b  in  4*DIGITS: BCD operand B, same layout; sampled with start.
- busy  out  1: high in ADD and NEG states.
- done  out  1: one-cycle pulse when the result registers are updated.
- s  out  4*DIGITS: BCD result magnitude.
- neg  out  1: result of a subtraction is negative.
- ovf  out  1: decimal carry out of the top digit on add; always 0 on subtract.
- err  out  1: an operand contained a digit greater than 9.

## Operation
- States: IDLE, ADD, NEG, DONE.
- **IDLE:**
  - If start=1, check every digit of a and b.
  - If any digit is greater than 9: go to DONE and load s=0, neg=0, ovf=0, err=1.
  - Otherwise latch A, and latch B' = b when op=0 or the per-digit nine's complement of b when op=1.
  - Set carry=op, digit index=0, clear the working result, and go to ADD.
- **ADD**, one digit per edge:
  - Compute t = A[i] + B'[i] + carry (5 bits).
  - If t > 9, the digit is t + 6 truncated to 4 bits and carry=1; otherwise the digit is t and carry=0.
  - Write the digit into working result digit i, then increment i.
  - On the edge that processes digit DIGITS−1, the exit uses the final carry:
    - op=0: load s=working, ovf=carry, neg=0, err=0; go to DONE.
    - op=1 with carry=1 (A ≥ B): load s=working, neg=0, ovf=0, err=0; go to DONE.
    - op=1 with carry=0 (A < B): go to NEG with i=0 and carry=1.
- **NEG**, one digit per edge:
  - Form the ten's complement of the working result: digit = ninecomp(W[i]) + carry, with the same decimal-correct rule as ADD.
  - On the last digit, load s=complemented word, neg=1, ovf=0, err=0; go to DONE.
- **DONE:** done=1 for exactly one cycle, then go to IDLE on the next edge. start is ignored in DONE.
- **Output holding:** s, neg, ovf and err change only on the edge that enters DONE. They hold their values through subsequent busy periods until the next completion.
- **Zero difference:** A−A yields s=0 and neg=0. A negative zero is never produced.
- **Addition overflow:** the result wraps modulo 10^DIGITS, with ovf=1.

## Timing
- Reset (synchronous): state=IDLE; s=0, neg=0, ovf=0, err=0, busy=0, done=0 after the edge.
- Reset in any state, including mid-ADD or NEG, aborts the operation. No done pulse is issued.
- Let E0 be the edge on which start is accepted.
  - Add, or subtract with a non-negative result: state=DONE after edge E_DIGITS, so done is high in the following cycle.
  - Subtract with a negative result: done is high after edge E_(2·DIGITS).
  - Invalid operand: done is high after E0 (1-cycle latency).
- busy rises after E0 and falls on the edge that enters DONE. busy and done are never high together.
- **start held high:** operations run back to back. Each done pulse is followed by one IDLE cycle before the next start is accepted.
- Operand inputs may change freely once E0 has passed. They are latched at E0.

## Test plan
- **Reset.** Assert reset for 2 cycles mid-ADD. Required: busy=0, done stays 0, s=0, neg=0, ovf=0, err=0, and state returns to IDLE.
- **Add with carry out (DIGITS=4).** a=16'h9876, b=16'h3333, op=0. Required: done exactly 4 cycles after the start edge, s=16'h3209, ovf=1, neg=0.
- **Non-negative subtract.** a=16'h5000, b=16'h1234, op=1. Required: done after 4 cycles, s=16'h3766, neg=0, ovf=0. Also run a=b=16'h4321, which must give s=0 and neg=0.
- **Negative subtract.** a=16'h0000, b=16'h0001, op=1. Required: busy for 8 cycles, done after 8 cycles, s=16'h0001, neg=1.
- **Invalid operand.** a=16'h00A0, op=0. Required: done 1 cycle after the start edge, err=1, s=0. Then a valid op must clear err.
- **Parameter and handshake.** With DIGITS=2, hold start high and run 99+01 then 10−25. Required: s=8'h00 with ovf=1, then s=8'h15 with neg=1. Exactly one IDLE cycle must separate the operations.

Source files
------------

// File: rtl/bcd_addsub_seq.sv
// Digit-serial BCD add/subtract engine: one decimal digit per clock, LSD first.
// Subtraction yields sign-magnitude; a negative raw result is re-complemented digit-serially.
module bcd_addsub_seq #(
  parameter int DIGITS = 4
) (
  input  logic                hz100,
  input  logic                reset,
  input  logic                start,
  input  logic                op,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] s,
  output logic                neg,
  output logic                ovf,
  output logic                err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [3:0] nine_comp(input logic [3:0] d);
    return 4'd9 - d;
  endfunction

  function automatic logic [W-1:0] nine_comp_word(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = nine_comp(v[4*k +: 4]);
    end
    return r;
  endfunction

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      bad = bad | (v[4*k +: 4] > 4'd9);
    end
    return bad;
  endfunction

  // Decimal-correct digit add: returns {carry_out, digit}.
  function automatic logic [4:0] digit_add(input logic [3:0] x, input logic [3:0] y,
                                           input logic cin);
    logic [4:0] t;
    logic [4:0] r;
    t = {1'b0, x} + {1'b0, y} + {4'd0, cin};
    if (t > 5'd9) begin
      r = {1'b1, t[3:0] + 4'd6};
    end else begin
      r = {1'b0, t[3:0]};
    end
    return r;
  endfunction

  state_t         state_q;
  logic [W-1:0]   a_q, b_q, w_q, s_q;
  logic [IW-1:0]  idx_q;
  logic           carry_q, op_q, neg_q, ovf_q, err_q, busy_q, done_q;

  logic [3:0]     a_dig_s, b_dig_s, w_dig_s, in1_s, in2_s;
  logic [4:0]     sum_s;
  logic [W-1:0]   w_d;
  logic           carry_d, last_s;

  // Digit datapath shared by ADD (A + B') and NEG (ninecomp(W) + carry).
  always_comb begin
    a_dig_s = 4'(a_q >> {idx_q, 2'b00});
    b_dig_s = 4'(b_q >> {idx_q, 2'b00});
    w_dig_s = 4'(w_q >> {idx_q, 2'b00});
    if (state_q == NEG) begin
      in1_s = nine_comp(w_dig_s);
      in2_s = 4'd0;
    end else begin
      in1_s = a_dig_s;
      in2_s = b_dig_s;
    end
    sum_s   = digit_add(in1_s, in2_s, carry_q);
    carry_d = sum_s[4];
    w_d     = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        w_d[4*k +: 4] = sum_s[3:0];
      end else begin
        w_d[4*k +: 4] = w_q[4*k +: 4];
      end
    end
    last_s = (idx_q == IW'(DIGITS - 1));
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge hz100) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      w_q     <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      op_q    <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            if (has_bad_digit(a) || has_bad_digit(b)) begin
              s_q     <= '0;
              neg_q   <= 1'b0;
              ovf_q   <= 1'b0;
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              a_q     <= a;
              b_q     <= op ? nine_comp_word(b) : b;
              op_q    <= op;
              carry_q <= op;
              idx_q   <= '0;
              w_q     <= '0;
              busy_q  <= 1'b1;
              state_q <= ADD;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        ADD: begin
          w_q     <= w_d;
          idx_q   <= idx_q + IW'(1);
          carry_q <= carry_d;
          if (last_s) begin
            // A borrow (no carry) on subtract means A < B: re-complement in NEG.
            if (op_q && !carry_d) begin
              idx_q   <= '0;
              carry_q <= 1'b1;
              state_q <= NEG;
            end else begin
              s_q     <= w_d;
              ovf_q   <= !op_q && carry_d;
              neg_q   <= 1'b0;
              err_q   <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end else begin
            state_q <= ADD;
          end
        end
        NEG: begin
          w_q     <= w_d;
          idx_q   <= idx_q + IW'(1);
          carry_q <= carry_d;
          if (last_s) begin
            s_q     <= w_d;
            neg_q   <= 1'b1;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= NEG;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign neg  = neg_q;
  assign ovf  = ovf_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_addsub_seq.sv
// Scoreboard bench for bcd_addsub_seq: drivers queue expected results, per-DUT monitors
// pop and compare on each done pulse (value, latency in edges, busy duration).
module tb_bcd_addsub_seq;

  typedef struct {
    logic [15:0] s;
    logic        neg;
    logic        ovf;
    logic        err;
    int          edges;
    int          start_cyc;
  } exp_t;

  logic        hz100 = 1'b0;
  logic        reset = 1'b1;
  logic        start4 = 1'b0, op4 = 1'b0;
  logic [15:0] a4 = 16'h0, b4 = 16'h0;
  logic        busy4, done4, neg4, ovf4, err4;
  logic [15:0] s4;
  logic        start2 = 1'b0, op2 = 1'b0;
  logic [7:0]  a2 = 8'h0, b2 = 8'h0;
  logic        busy2, done2, neg2, ovf2, err2;
  logic [7:0]  s2;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t q4[$];
  exp_t q2[$];

  bcd_addsub_seq #(.DIGITS(4)) dut4 (
    .hz100(hz100), .reset(reset), .start(start4), .op(op4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .s(s4), .neg(neg4), .ovf(ovf4), .err(err4)
  );

  bcd_addsub_seq #(.DIGITS(2)) dut2 (
    .hz100(hz100), .reset(reset), .start(start2), .op(op2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .s(s2), .neg(neg2), .ovf(ovf2), .err(err2)
  );

  initial forever #5 hz100 = ~hz100;

  initial forever begin
    @(posedge hz100);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] sv, input logic nv, input logic ov,
                              input logic ev, input int edges);
    exp_t e;
    e.s = sv; e.neg = nv; e.ovf = ov; e.err = ev; e.edges = edges; e.start_cyc = 0;
    return e;
  endfunction

  // Monitor for the 4-digit instance
  initial begin
    int   busy_cnt;
    exp_t e;
    busy_cnt = 0;
    forever begin
      @(negedge hz100);
      if (reset) begin
        busy_cnt = 0;
      end else begin
        if (busy4) busy_cnt++;
        if (done4) begin
          if (q4.size() == 0) begin
            chk("unexpected_done4", 32'd1, 32'd0);
          end else begin
            e = q4.pop_front();
            chk("s4", 32'(s4), 32'(e.s));
            chk("neg4", 32'(neg4), 32'(e.neg));
            chk("ovf4", 32'(ovf4), 32'(e.ovf));
            chk("err4", 32'(err4), 32'(e.err));
            chk("latency4", 32'(cyc - e.start_cyc), 32'(e.edges));
            chk("busy_cycles4", 32'(busy_cnt), 32'(e.edges));
            chk("busy_with_done4", 32'(busy4), 32'd0);
          end
          busy_cnt = 0;
        end
      end
    end
  end

  // Monitor for the 2-digit instance
  initial begin
    int   busy_cnt;
    exp_t e;
    busy_cnt = 0;
    forever begin
      @(negedge hz100);
      if (reset) begin
        busy_cnt = 0;
      end else begin
        if (busy2) busy_cnt++;
        if (done2) begin
          if (q2.size() == 0) begin
            chk("unexpected_done2", 32'd1, 32'd0);
          end else begin
            e = q2.pop_front();
            chk("s2", 32'(s2), 32'(e.s));
            chk("neg2", 32'(neg2), 32'(e.neg));
            chk("ovf2", 32'(ovf2), 32'(e.ovf));
            chk("err2", 32'(err2), 32'(e.err));
            chk("latency2", 32'(cyc - e.start_cyc), 32'(e.edges));
            chk("busy_cycles2", 32'(busy_cnt), 32'(e.edges));
            chk("busy_with_done2", 32'(busy2), 32'd0);
          end
          busy_cnt = 0;
        end
      end
    end
  end

  task automatic launch4(input logic [15:0] av, input logic [15:0] bv, input logic opv,
                         input exp_t e);
    @(negedge hz100);
    a4 = av; b4 = bv; op4 = opv; start4 = 1'b1;
    e.start_cyc = cyc + 1;
    q4.push_back(e);
    @(negedge hz100);
    start4 = 1'b0;
    a4 = 16'hFFFF; b4 = 16'hFFFF; op4 = ~opv;
  endtask

  task automatic drain4();
    for (int i = 0; i < 60 && q4.size() != 0; i++) @(negedge hz100);
    chk("timeout4", 32'(q4.size()), 32'd0);
    q4.delete();
  endtask

  task automatic run4(input logic [15:0] av, input logic [15:0] bv, input logic opv,
                      input exp_t e);
    launch4(av, bv, opv, e);
    drain4();
  endtask

  initial begin
    int c0;
    repeat (3) @(negedge hz100);
    reset = 1'b0;
    chk("rst_s4", 32'(s4), 32'd0);
    chk("rst_flags4", {28'd0, busy4, done4, neg4, ovf4}, 32'd0);
    chk("rst_err4", 32'(err4), 32'd0);
    chk("rst_s2", 32'(s2), 32'd0);
    chk("rst_flags2", {27'd0, busy2, done2, neg2, ovf2, err2}, 32'd0);

    run4(16'h9876, 16'h3333, 1'b0, mk(16'h3209, 1'b0, 1'b1, 1'b0, 4));
    run4(16'h5000, 16'h1234, 1'b1, mk(16'h3766, 1'b0, 1'b0, 1'b0, 4));
    run4(16'h4321, 16'h4321, 1'b1, mk(16'h0000, 1'b0, 1'b0, 1'b0, 4));
    run4(16'h0000, 16'h0001, 1'b1, mk(16'h0001, 1'b1, 1'b0, 1'b0, 8));
    run4(16'h1234, 16'h8765, 1'b0, mk(16'h9999, 1'b0, 1'b0, 1'b0, 4));
    run4(16'h0250, 16'h1000, 1'b1, mk(16'h0750, 1'b1, 1'b0, 1'b0, 8));
    run4(16'h00A0, 16'h0000, 1'b0, mk(16'h0000, 1'b0, 1'b0, 1'b1, 0));
    run4(16'h0000, 16'hF000, 1'b1, mk(16'h0000, 1'b0, 1'b0, 1'b1, 0));

    // Error result must hold through the next busy period, then clear on completion.
    launch4(16'h0123, 16'h0456, 1'b0, mk(16'h0579, 1'b0, 1'b0, 1'b0, 4));
    @(negedge hz100);
    chk("hold_err4", 32'(err4), 32'd1);
    chk("hold_s4", 32'(s4), 32'd0);
    chk("hold_busy4", 32'(busy4), 32'd1);
    drain4();

    // Reset mid-ADD aborts: no done, outputs cleared, back to idle.
    @(negedge hz100);
    a4 = 16'h1234; b4 = 16'h1111; op4 = 1'b0; start4 = 1'b1;
    @(negedge hz100);
    start4 = 1'b0;
    @(negedge hz100);
    chk("pre_reset_busy4", 32'(busy4), 32'd1);
    reset = 1'b1;
    repeat (2) @(negedge hz100);
    reset = 1'b0;
    chk("abort_busy4", 32'(busy4), 32'd0);
    chk("abort_done4", 32'(done4), 32'd0);
    chk("abort_s4", 32'(s4), 32'd0);
    chk("abort_flags4", {29'd0, neg4, ovf4, err4}, 32'd0);
    repeat (8) @(negedge hz100);
    chk("abort_idle4", {30'd0, busy4, done4}, 32'd0);

    // Back-to-back with start held high on the 2-digit instance.
    @(negedge hz100);
    a2 = 8'h99; b2 = 8'h01; op2 = 1'b0; start2 = 1'b1;
    c0 = cyc + 1;
    q2.push_back(mk(16'h0000, 1'b0, 1'b1, 1'b0, 2));
    q2.push_back(mk(16'h0015, 1'b1, 1'b0, 1'b0, 4));
    q2[0].start_cyc = c0;
    q2[1].start_cyc = c0 + 4;
    @(negedge hz100);
    a2 = 8'h10; b2 = 8'h25; op2 = 1'b1;
    repeat (4) @(negedge hz100);
    start2 = 1'b0;
    for (int i = 0; i < 60 && q2.size() != 0; i++) @(negedge hz100);
    chk("timeout2", 32'(q2.size()), 32'd0);
    q2.delete();
    repeat (4) @(negedge hz100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "bench did not finish");
  end

endmodule
